// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the rv32 memory-port arbiter.
// Request function/mask encodings match the core's M_* / MT_* values.
package mem_port_arbiter_pkg;

    localparam int TYP_W = 3;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam logic [TYP_W-1:0] MT_X  = 3'd0;
    localparam logic [TYP_W-1:0] MT_B  = 3'd1;
    localparam logic [TYP_W-1:0] MT_H  = 3'd2;
    localparam logic [TYP_W-1:0] MT_W  = 3'd3;
    localparam logic [TYP_W-1:0] MT_D  = 3'd4;
    localparam logic [TYP_W-1:0] MT_BU = 3'd5;
    localparam logic [TYP_W-1:0] MT_HU = 3'd6;
    localparam logic [TYP_W-1:0] MT_WU = 3'd7;

    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} t_owner;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} t_arb_state;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response memory port. The master issues requests; the slave
// accepts them and returns one response per accepted request.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_data;
    logic             req_fcn;
    logic [TYP_W-1:0] req_typ;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_data;

    modport master (
        output req_valid, req_addr, req_data, req_fcn, req_typ,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_fcn, req_typ,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/mem_port_arbiter_arb_prio_pick.sv
// Two-way picker: dmem by default, imem once it has lost STARVE_LIMIT
// consecutive contested grants. Holds the starvation counter.
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  logic   d_valid,
    input  logic   accept,
    output t_owner winner
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        winner = OWN_D;
        if (i_valid && (!d_valid || starve_cnt_q >= LIMIT))
            winner = OWN_I;
    end

    // Only contested dmem wins count; uncontested ones leave the counter alone.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (accept) begin
            if (winner == OWN_I)
                starve_cnt_d = '0;
            else if (i_valid && starve_cnt_q < LIMIT)
                starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem),
// keeping a single transaction outstanding and routing its response back.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     imem,
    mem_port_arbiter_if.slave     dmem,
    mem_port_arbiter_if.master    mem,
    output logic                  err_spurious
);
    t_arb_state state_q, state_d;
    t_owner     owner_q, owner_d;
    logic       err_q, err_d;

    t_owner winner;
    logic   resp_hit, issue_ok, any_valid, accept;

    // A response frees the port in the same cycle, so a new request can go out.
    assign resp_hit  = (state_q == ARB_BUSY) && mem.resp_valid;
    assign issue_ok  = (state_q == ARB_IDLE) || resp_hit;
    assign any_valid = imem.req_valid || dmem.req_valid;
    assign accept    = !rst && issue_ok && any_valid && mem.req_ready;

    arb_prio_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .i_valid (imem.req_valid),
        .d_valid (dmem.req_valid),
        .accept  (accept),
        .winner  (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_I;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = err_q;
        if (accept) begin
            state_d = ARB_BUSY;
            owner_d = winner;
        end else if (resp_hit) begin
            state_d = ARB_IDLE;
        end
        if (state_q == ARB_IDLE && mem.resp_valid)
            err_d = 1'b1;
    end

    always_comb begin
        mem.req_valid   = 1'b0;
        mem.req_addr    = '0;
        mem.req_data    = '0;
        mem.req_fcn     = M_XRD;
        mem.req_typ     = MT_X;
        imem.req_ready  = 1'b0;
        dmem.req_ready  = 1'b0;
        imem.resp_valid = 1'b0;
        imem.resp_data  = '0;
        dmem.resp_valid = 1'b0;
        dmem.resp_data  = '0;
        if (!rst) begin
            mem.req_valid = issue_ok && any_valid;
            if (winner == OWN_I) begin
                mem.req_addr = imem.req_addr;
                mem.req_typ  = MT_WU;
            end else begin
                mem.req_addr = dmem.req_addr;
                mem.req_data = dmem.req_data;
                mem.req_fcn  = dmem.req_fcn;
                mem.req_typ  = dmem.req_typ;
            end
            imem.req_ready = accept && (winner == OWN_I);
            dmem.req_ready = accept && (winner == OWN_D);
            if (resp_hit && owner_q == OWN_I) begin
                imem.resp_valid = 1'b1;
                imem.resp_data  = mem.resp_data;
            end
            if (resp_hit && owner_q == OWN_D) begin
                dmem.resp_valid = 1'b1;
                dmem.resp_data  = mem.resp_data;
            end
        end
    end

    assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_spurious;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if #(.XLEN(XLEN)) imem_if ();
    mem_port_arbiter_if #(.XLEN(XLEN)) dmem_if ();
    mem_port_arbiter_if #(.XLEN(XLEN)) mem_if ();

    mem_port_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_if),
        .dmem         (dmem_if),
        .mem          (mem_if),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_if.req_valid = 1'b0;
        imem_if.req_addr  = '0;
        imem_if.req_data  = '0;
        imem_if.req_fcn   = 1'b0;
        imem_if.req_typ   = '0;
        dmem_if.req_valid = 1'b0;
        dmem_if.req_addr  = '0;
        dmem_if.req_data  = '0;
        dmem_if.req_fcn   = 1'b0;
        dmem_if.req_typ   = '0;
        mem_if.req_ready  = 1'b0;
        mem_if.resp_valid = 1'b0;
        mem_if.resp_data  = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        imem_if.req_valid = 1'b1;
        dmem_if.req_valid = 1'b1;
        mem_if.req_ready  = 1'b1;
        mem_if.resp_valid = 1'b1;
        sample();
        total++; if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got %b want 0", mem_if.req_valid); end
        total++; if ({imem_if.req_ready, dmem_if.req_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready got %b want 00", {imem_if.req_ready, dmem_if.req_ready}); end
        total++; if ({imem_if.resp_valid, dmem_if.resp_valid} !== 2'b00) begin bad++; $display("FAIL rst_resp got %b want 00", {imem_if.resp_valid, dmem_if.resp_valid}); end
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err_spurious); end
        step();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        int ipulses = 0;
        int dpulses = 0;
        logic [XLEN-1:0] idata = '0;
        step();
        imem_if.req_valid = 1'b1;
        imem_if.req_addr  = 32'h100;
        mem_if.req_ready  = 1'b1;
        sample();
        total++; if (imem_if.req_ready !== 1'b1) begin bad++; $display("FAIL fetch_ready got %b want 1", imem_if.req_ready); end
        total++; if ({mem_if.req_valid, mem_if.req_addr, mem_if.req_data, mem_if.req_fcn, mem_if.req_typ} !== {1'b1, 32'h100, 32'h0, M_XRD, MT_WU})
            begin bad++; $display("FAIL fetch_fields got v=%b a=%h d=%h f=%b t=%0d want v=1 a=100 d=0 f=0 t=7", mem_if.req_valid, mem_if.req_addr, mem_if.req_data, mem_if.req_fcn, mem_if.req_typ); end
        step();
        imem_if.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            mem_if.resp_valid = (k == 3);
            mem_if.resp_data  = (k == 3) ? 32'h13 : 32'hdead;
            sample();
            if (imem_if.req_ready) ipulses += 100;
            if (imem_if.resp_valid) begin ipulses++; idata = imem_if.resp_data; end
            if (dmem_if.resp_valid) dpulses++;
        end
        total++; if (ipulses !== 1) begin bad++; $display("FAIL fetch_pulses got %0d want 1", ipulses); end
        total++; if (idata !== 32'h13) begin bad++; $display("FAIL fetch_data got %h want 00000013", idata); end
        total++; if (dpulses !== 0) begin bad++; $display("FAIL fetch_dmem_resp got %0d want 0", dpulses); end
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        step();
        imem_if.req_valid = 1'b1;
        imem_if.req_addr  = 32'h300;
        dmem_if.req_valid = 1'b1;
        dmem_if.req_addr  = 32'h200;
        dmem_if.req_fcn   = M_XRD;
        dmem_if.req_typ   = MT_W;
        mem_if.req_ready  = 1'b1;
        sample();
        total++; if ({imem_if.req_ready, dmem_if.req_ready, mem_if.req_addr} !== {2'b01, 32'h200})
            begin bad++; $display("FAIL b2b_first got i=%b d=%b a=%h want i=0 d=1 a=200", imem_if.req_ready, dmem_if.req_ready, mem_if.req_addr); end
        step();
        dmem_if.req_valid = 1'b0;
        sample();
        total++; if (mem_if.req_valid !== 1'b0) begin bad++; $display("FAIL b2b_busy_valid got %b want 0", mem_if.req_valid); end
        step();
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = 32'hd0d0;
        sample();
        total++; if ({dmem_if.resp_valid, dmem_if.resp_data, imem_if.resp_valid} !== {1'b1, 32'hd0d0, 1'b0})
            begin bad++; $display("FAIL b2b_dresp got dv=%b dd=%h iv=%b want dv=1 dd=d0d0 iv=0", dmem_if.resp_valid, dmem_if.resp_data, imem_if.resp_valid); end
        total++; if ({imem_if.req_ready, mem_if.req_valid, mem_if.req_addr, mem_if.req_typ} !== {1'b1, 1'b1, 32'h300, MT_WU})
            begin bad++; $display("FAIL b2b_igrant got r=%b v=%b a=%h t=%0d want r=1 v=1 a=300 t=7", imem_if.req_ready, mem_if.req_valid, mem_if.req_addr, mem_if.req_typ); end
        step();
        imem_if.req_valid = 1'b0;
        mem_if.resp_valid = 1'b0;
        step();
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = 32'h1111;
        sample();
        total++; if ({imem_if.resp_valid, imem_if.resp_data, dmem_if.resp_valid} !== {1'b1, 32'h1111, 1'b0})
            begin bad++; $display("FAIL b2b_iresp got iv=%b id=%h dv=%b want iv=1 id=1111 dv=0", imem_if.resp_valid, imem_if.resp_data, dmem_if.resp_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_starvation();
        int starve = 0;
        string got;
        string want;
        step();
        imem_if.req_valid = 1'b1;
        imem_if.req_addr  = 32'h500;
        dmem_if.req_valid = 1'b1;
        dmem_if.req_addr  = 32'h600;
        mem_if.req_ready  = 1'b1;
        for (int g = 0; g < 6; g++) begin
            if (g > 0) begin
                step();
                mem_if.resp_valid = 1'b1;
                mem_if.resp_data  = g;
            end
            sample();
            got  = imem_if.req_ready ? "I" : (dmem_if.req_ready ? "D" : "-");
            want = (starve >= LIMIT) ? "I" : "D";
            if (want == "I") starve = 0;
            else if (starve < LIMIT) starve++;
            total++; if (got != want) begin bad++; $display("FAIL starve_grant%0d got %s want %s", g, got, want); end
        end
        step();
        imem_if.req_valid = 1'b0;
        dmem_if.req_valid = 1'b0;
        mem_if.resp_valid = 1'b1;
        sample();
        total++; if ({imem_if.resp_valid, dmem_if.resp_valid} !== 2'b01) begin bad++; $display("FAIL starve_last_resp got %b want 01", {imem_if.resp_valid, dmem_if.resp_valid}); end
        step();
        idle_inputs();
    endtask

    task automatic test_store_stall();
        step();
        dmem_if.req_valid = 1'b1;
        dmem_if.req_addr  = 32'h400;
        dmem_if.req_data  = 32'hab;
        dmem_if.req_fcn   = M_XWR;
        dmem_if.req_typ   = MT_B;
        mem_if.req_ready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step();
            sample();
            total++; if ({mem_if.req_valid, mem_if.req_addr, mem_if.req_data, mem_if.req_fcn, mem_if.req_typ, dmem_if.req_ready} !== {1'b1, 32'h400, 32'hab, M_XWR, MT_B, 1'b0})
                begin bad++; $display("FAIL store_stall%0d got v=%b a=%h d=%h f=%b t=%0d r=%b want v=1 a=400 d=ab f=1 t=1 r=0", c, mem_if.req_valid, mem_if.req_addr, mem_if.req_data, mem_if.req_fcn, mem_if.req_typ, dmem_if.req_ready); end
        end
        step();
        mem_if.req_ready = 1'b1;
        sample();
        total++; if (dmem_if.req_ready !== 1'b1) begin bad++; $display("FAIL store_ready got %b want 1", dmem_if.req_ready); end
        step();
        dmem_if.req_valid = 1'b0;
        step();
        mem_if.resp_valid = 1'b1;
        sample();
        total++; if ({imem_if.resp_valid, dmem_if.resp_valid} !== 2'b01) begin bad++; $display("FAIL store_ack got %b want 01", {imem_if.resp_valid, dmem_if.resp_valid}); end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        bit busy = 0;
        bit own_d = 0;
        int starve = 0;
        int lat = 0;
        int errs = 0;
        bit iv, dv, resp, pick_i, exp_mv;
        logic [XLEN-1:0] exp_addr, exp_data;
        logic exp_fcn;
        logic [TYP_W-1:0] exp_typ;
        apply_reset();
        for (int n = 0; n < 500; n++) begin
            step();
            iv = ($urandom % 3) != 0;
            dv = ($urandom % 3) != 0;
            imem_if.req_valid = iv;
            imem_if.req_addr  = $urandom;
            imem_if.req_data  = $urandom;
            imem_if.req_fcn   = 1'($urandom);
            imem_if.req_typ   = 3'($urandom);
            dmem_if.req_valid = dv;
            dmem_if.req_addr  = $urandom;
            dmem_if.req_data  = $urandom;
            dmem_if.req_fcn   = 1'($urandom);
            dmem_if.req_typ   = 3'($urandom);
            mem_if.req_ready  = ($urandom % 4) != 0;
            resp = 0;
            if (busy) begin
                lat--;
                resp = (lat == 0);
            end
            mem_if.resp_valid = resp;
            mem_if.resp_data  = $urandom;
            sample();
            pick_i = iv && (!dv || starve >= LIMIT);
            exp_mv = (!busy || resp) && (iv || dv);
            exp_addr = pick_i ? imem_if.req_addr : dmem_if.req_addr;
            exp_data = pick_i ? 32'h0 : dmem_if.req_data;
            exp_fcn  = pick_i ? M_XRD : dmem_if.req_fcn;
            exp_typ  = pick_i ? MT_WU : dmem_if.req_typ;
            total++; if ({mem_if.req_valid, imem_if.req_ready, dmem_if.req_ready} !== {exp_mv, exp_mv && mem_if.req_ready && pick_i, exp_mv && mem_if.req_ready && !pick_i})
                begin bad++; $display("FAIL rnd_grant cyc %0d got v=%b ir=%b dr=%b want v=%b pick_i=%b rdy=%b", n, mem_if.req_valid, imem_if.req_ready, dmem_if.req_ready, exp_mv, pick_i, mem_if.req_ready); end
            if (exp_mv) begin
                total++; if ({mem_if.req_addr, mem_if.req_data, mem_if.req_fcn, mem_if.req_typ} !== {exp_addr, exp_data, exp_fcn, exp_typ})
                    begin bad++; $display("FAIL rnd_fields cyc %0d got a=%h d=%h f=%b t=%0d want a=%h d=%h f=%b t=%0d", n, mem_if.req_addr, mem_if.req_data, mem_if.req_fcn, mem_if.req_typ, exp_addr, exp_data, exp_fcn, exp_typ); end
            end
            total++; if ({imem_if.resp_valid, dmem_if.resp_valid} !== {resp && !own_d, resp && own_d})
                begin bad++; $display("FAIL rnd_route cyc %0d got iv=%b dv=%b want iv=%b dv=%b", n, imem_if.resp_valid, dmem_if.resp_valid, resp && !own_d, resp && own_d); end
            if (resp) begin
                total++; if ((own_d ? dmem_if.resp_data : imem_if.resp_data) !== mem_if.resp_data)
                    begin bad++; $display("FAIL rnd_rdata cyc %0d got %h want %h", n, own_d ? dmem_if.resp_data : imem_if.resp_data, mem_if.resp_data); end
            end
            if (exp_mv && mem_if.req_ready) begin
                busy  = 1;
                own_d = !pick_i;
                lat   = $urandom_range(1, 3);
                if (pick_i) starve = 0;
                else if (iv && starve < LIMIT) starve++;
            end else if (resp) begin
                busy = 0;
            end
        end
        if (err_spurious !== 1'b0) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL rnd_err got %b want 0", err_spurious); end
        step();
        idle_inputs();
        if (busy) begin
            repeat (lat - 1) step();
            mem_if.resp_valid = 1'b1;
            step();
            mem_if.resp_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        step();
        dmem_if.req_valid = 1'b1;
        dmem_if.req_addr  = 32'h700;
        dmem_if.req_typ   = MT_W;
        mem_if.req_ready  = 1'b1;
        sample();
        total++; if (dmem_if.req_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept got %b want 1", dmem_if.req_ready); end
        step();
        dmem_if.req_valid = 1'b0;
        #2 rst = 1'b1;
        dmem_if.req_valid = 1'b1;
        #1;
        total++; if ({mem_if.req_valid, dmem_if.req_ready, err_spurious} !== 3'b000)
            begin bad++; $display("FAIL rmid_in_rst got v=%b r=%b e=%b want 000", mem_if.req_valid, dmem_if.req_ready, err_spurious); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dmem_if.req_valid = 1'b0;
        step();
        step();
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = 32'hbad;
        sample();
        total++; if ({imem_if.resp_valid, dmem_if.resp_valid} !== 2'b00) begin bad++; $display("FAIL rmid_late_resp got %b want 00", {imem_if.resp_valid, dmem_if.resp_valid}); end
        step();
        mem_if.resp_valid = 1'b0;
        sample();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL rmid_err got %b want 1", err_spurious); end
        repeat (3) step();
        sample();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL rmid_err_held got %b want 1", err_spurious); end
        idle_inputs();
    endtask

    task automatic test_spurious_idle();
        apply_reset();
        sample();
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_clean got %b want 0", err_spurious); end
        step();
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = 32'h5555;
        sample();
        total++; if ({imem_if.resp_valid, dmem_if.resp_valid, mem_if.req_valid} !== 3'b000)
            begin bad++; $display("FAIL spur_no_resp got %b want 000", {imem_if.resp_valid, dmem_if.resp_valid, mem_if.req_valid}); end
        step();
        mem_if.resp_valid = 1'b0;
        sample();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_err got %b want 1", err_spurious); end
        repeat (4) step();
        sample();
        total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_err_held got %b want 1", err_spurious); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_starvation();
        test_store_stall();
        test_random();
        test_reset_mid();
        test_spurious_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
